// File: rtl/matmul_tile_accumulator_if.sv
// matmul_tile_accumulator_if
//   Operand-in / result-out bundle for matmul_tile_accumulator.
//   master : operand streamer + result consumer (drives valid_in, A, B, C,
//            num_tiles_i, mode_i, ready_out)
//   slave  : the accumulator (drives ready_in, D, valid_out)
//   A[i][k], B[k][j], C[i][j], D[i][j] are packed, element index outermost.
interface matmul_tile_accumulator_if #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int P         = 8,
  parameter int ACC_W     = 32,
  parameter int MAX_TILES = 16
);
  localparam int NT_W = $clog2(MAX_TILES + 1);

  logic                              valid_in;
  logic                              ready_in;
  logic [M-1:0][K-1:0][P-1:0]        A;
  logic [K-1:0][N-1:0][P-1:0]        B;
  logic [M-1:0][N-1:0][ACC_W-1:0]    C;
  logic [NT_W-1:0]                   num_tiles_i;
  logic [1:0]                        mode_i;
  logic [M-1:0][N-1:0][ACC_W-1:0]    D;
  logic                              valid_out;
  logic                              ready_out;

  modport master (
    output valid_in, A, B, C, num_tiles_i, mode_i, ready_out,
    input  ready_in, D, valid_out
  );

  modport slave (
    input  valid_in, A, B, C, num_tiles_i, mode_i, ready_out,
    output ready_in, D, valid_out
  );
endinterface

// File: rtl/matmul_tile_accumulator.sv
// matmul_tile_accumulator
//   Accumulates D = C + sum_t(A_t x B_t) over a stream of K-tiles, then
//   presents D on a registered valid/ready output.
//   Ports:
//     clk_i   : clock
//     rst_ni  : synchronous active-low reset
//     bus     : matmul_tile_accumulator_if.slave (operand beats in, D out)
//     busy_o  : high while accumulating or holding a result
//   Modes (latched on first beat): 00/11 full PxP, 10 two packed P/2
//   subword pairs per element, 01 full A x signed low half of B.

// One output element: dot product of an A row with a B column, added to base.
module matmul_tile_cell #(
  parameter int K        = 2,
  parameter int P        = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic [K-1:0][P-1:0] a_i,
  input  logic [K-1:0][P-1:0] b_i,
  input  logic [1:0]          mode_i,
  input  logic [ACC_W-1:0]    base_i,
  output logic [ACC_W-1:0]    sum_o
);
  // Products are summed at full precision so that a narrow ACC_W still
  // clamps on the true value; for ACC_W >= PW this equals ACC_W-wide math,
  // and in wrap mode truncation is the same as a modulo-2^ACC_W sum.
  localparam int PW = 2*P + $clog2(2*K) + 1;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  logic signed [2*P-1:0] af, bf, ah, al, bh, bl, e;
  logic signed [PW-1:0]  prod;
  logic [SW-1:0]         s;
  logic                  ovf;

  always_comb begin
    prod = '0;
    af = '0; bf = '0; ah = '0; al = '0; bh = '0; bl = '0; e = '0;
    for (int k = 0; k < K; k++) begin
      af = {{P{a_i[k][P-1]}}, a_i[k]};
      bf = {{P{b_i[k][P-1]}}, b_i[k]};
      ah = {{(P+P/2){a_i[k][P-1]}},   a_i[k][P-1:P/2]};
      al = {{(P+P/2){a_i[k][P/2-1]}}, a_i[k][P/2-1:0]};
      bh = {{(P+P/2){b_i[k][P-1]}},   b_i[k][P-1:P/2]};
      bl = {{(P+P/2){b_i[k][P/2-1]}}, b_i[k][P/2-1:0]};
      case (mode_i)
        2'b10:   e = ah * bh + al * bl;
        2'b01:   e = af * bl;
        default: e = af * bf;
      endcase
      prod = prod + {{(PW-2*P){e[2*P-1]}}, e};
    end
    s   = {{(SW-ACC_W){base_i[ACC_W-1]}}, base_i} + {{(SW-PW){prod[PW-1]}}, prod};
    // Result fits in ACC_W signed only if all bits above the sign agree.
    ovf = (s[SW-1:ACC_W-1] != {(SW-ACC_W+1){s[SW-1]}});
    if (SATURATE != 0 && ovf)
      sum_o = s[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum_o = s[ACC_W-1:0];
  end
endmodule

module matmul_tile_accumulator #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int P         = 8,
  parameter int ACC_W     = 32,
  parameter int MAX_TILES = 16,
  parameter int SATURATE  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  matmul_tile_accumulator_if.slave     bus,
  output logic                         busy_o
);
  localparam int NT_W = $clog2(MAX_TILES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_e;

  state_e                          state_q;
  logic [M-1:0][N-1:0][ACC_W-1:0]  acc_q, d_q, base_w, sum_w;
  logic [NT_W-1:0]                 cnt_q, nt_q, nt_eff, cnt_inc;
  logic [1:0]                      mode_q, mode_eff;
  logic                            vo_q, busy_q;
  logic [N-1:0][K-1:0][P-1:0]      b_col;

  // First beat uses live sideband inputs; later beats use the latched copy.
  assign mode_eff = (state_q == S_IDLE) ? bus.mode_i : mode_q;
  assign cnt_inc  = cnt_q + NT_W'(1);

  always_comb begin
    nt_eff = bus.num_tiles_i;
    if (bus.num_tiles_i == '0)                   nt_eff = NT_W'(1);
    else if (bus.num_tiles_i > NT_W'(MAX_TILES)) nt_eff = NT_W'(MAX_TILES);
  end

  always_comb begin
    b_col = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++)
        b_col[j][k] = bus.B[k][j];
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign base_w[i][j] = (state_q == S_IDLE) ? bus.C[i][j] : acc_q[i][j];
      matmul_tile_cell #(.K(K), .P(P), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_cell (
        .a_i    (bus.A[i]),
        .b_i    (b_col[j]),
        .mode_i (mode_eff),
        .base_i (base_w[i][j]),
        .sum_o  (sum_w[i][j])
      );
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      nt_q    <= '0;
      mode_q  <= '0;
      vo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.valid_in) begin
          acc_q  <= sum_w;
          cnt_q  <= NT_W'(1);
          nt_q   <= nt_eff;
          mode_q <= bus.mode_i;
          busy_q <= 1'b1;
          if (nt_eff == NT_W'(1)) begin
            state_q <= S_OUT;
            d_q     <= sum_w;
            vo_q    <= 1'b1;
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: if (bus.valid_in) begin
          acc_q <= sum_w;
          cnt_q <= cnt_inc;
          if (cnt_inc == nt_q) begin
            state_q <= S_OUT;
            d_q     <= sum_w;
            vo_q    <= 1'b1;
          end
        end
        S_OUT: if (bus.ready_out) begin
          state_q <= S_IDLE;
          vo_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_in  = rst_ni && (state_q != S_OUT);
  assign bus.D         = d_q;
  assign bus.valid_out = vo_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_matmul_tile_accumulator.sv
module tb_matmul_tile_accumulator;
  localparam int MT = 16;

  typedef logic [1:0][1:0][7:0]  tile_t;
  typedef logic [1:0][1:0][31:0] mat_t;
  typedef struct {
    string      nm;
    tile_t      a;
    tile_t      b;
    mat_t       c;
    logic [1:0] mode;
    logic [4:0] nt;
    int         gap;
    mat_t       d;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy_s;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  matmul_tile_accumulator_if #(.M(2), .N(2), .K(2), .P(8), .ACC_W(32), .MAX_TILES(MT)) bus ();
  matmul_tile_accumulator_if #(.M(2), .N(2), .K(2), .P(8), .ACC_W(8),  .MAX_TILES(MT)) bus_s ();

  matmul_tile_accumulator #(.M(2), .N(2), .K(2), .P(8), .ACC_W(32), .MAX_TILES(MT), .SATURATE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy));
  matmul_tile_accumulator #(.M(2), .N(2), .K(2), .P(8), .ACC_W(8), .MAX_TILES(MT), .SATURATE(1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_s), .busy_o(busy_s));

  function automatic mat_t mk(int v00, int v01, int v10, int v11);
    mat_t m;
    m[0][0] = 32'(v00); m[0][1] = 32'(v01); m[1][0] = 32'(v10); m[1][1] = 32'(v11);
    return m;
  endfunction

  function automatic tile_t mt(int v00, int v01, int v10, int v11);
    tile_t t;
    t[0][0] = 8'(v00); t[0][1] = 8'(v01); t[1][0] = 8'(v10); t[1][1] = 8'(v11);
    return t;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive all beats of one transaction; sideband inputs are scrambled after
  // the first beat so the bench notices if ACCUM samples them.
  task automatic feed(string nm, tile_t a, tile_t b, mat_t c, logic [1:0] mode,
                      logic [4:0] nt, int gap);
    int nb;
    nb = (nt == 0) ? 1 : ((int'(nt) > MT) ? MT : int'(nt));
    for (int t = 0; t < nb; t++) begin
      bus.A = a;
      bus.B = b;
      if (t == 0) begin
        bus.C = c; bus.num_tiles_i = nt; bus.mode_i = mode;
      end else begin
        bus.C = mk(85, 85, 85, 85); bus.num_tiles_i = 5'd1; bus.mode_i = mode ^ 2'b10;
      end
      bus.valid_in = 1'b1;
      chk({nm, ".ready_in"}, 128'(bus.ready_in), 128'(1));
      step();
      bus.valid_in = 1'b0;
      if (t < nb - 1) begin
        chk({nm, ".early_vo"}, 128'(bus.valid_out), 128'(0));
        for (int g = 0; g < gap; g++) step();
      end
    end
    chk({nm, ".lat_vo"}, 128'(bus.valid_out), 128'(1));
    chk({nm, ".busy"}, 128'(busy), 128'(1));
  endtask

  task automatic drain(string nm, mat_t exp);
    chk({nm, ".D"}, 128'(bus.D), 128'(exp));
    bus.ready_out = 1'b1;
    step();
    bus.ready_out = 1'b0;
    chk({nm, ".vo_drop"}, 128'(bus.valid_out), 128'(0));
    chk({nm, ".rdy_back"}, 128'(bus.ready_in), 128'(1));
    chk({nm, ".idle"}, 128'(busy), 128'(0));
  endtask

  vec_t  tv[9];
  tile_t a1, b1;
  mat_t  d1;

  initial begin
    a1 = mt(1, 2, 3, 4);
    b1 = mt(5, 6, 7, 8);
    d1 = mk(20, 23, 44, 51);
    tv[0] = '{nm:"single00", a:a1, b:b1, c:mk(1,1,1,1), mode:2'b00, nt:5'd1, gap:0, d:d1};
    tv[1] = '{nm:"three",    a:a1, b:b1, c:mk(0,0,0,0), mode:2'b00, nt:5'd3, gap:0, d:mk(57,66,129,150)};
    tv[2] = '{nm:"three_gap",a:a1, b:b1, c:mk(0,0,0,0), mode:2'b00, nt:5'd3, gap:2, d:mk(57,66,129,150)};
    tv[3] = '{nm:"halved",   a:mt(35,35,35,35), b:mt(79,79,79,79), c:mk(0,0,0,0), mode:2'b10, nt:5'd1, gap:0, d:mk(10,10,10,10)};
    tv[4] = '{nm:"mixed",    a:mt(128,128,128,128), b:mt(255,255,255,255), c:mk(0,0,0,0), mode:2'b01, nt:5'd1, gap:0, d:mk(256,256,256,256)};
    tv[5] = '{nm:"mode11",   a:a1, b:b1, c:mk(0,0,0,0), mode:2'b11, nt:5'd1, gap:0, d:mk(19,22,43,50)};
    tv[6] = '{nm:"nt_zero",  a:a1, b:b1, c:mk(1,1,1,1), mode:2'b00, nt:5'd0, gap:0, d:d1};
    tv[7] = '{nm:"wrap",     a:mt(127,127,127,127), b:mt(127,127,127,127),
              c:mk(32'h7fffffff,32'h7fffffff,32'h7fffffff,32'h7fffffff), mode:2'b00, nt:5'd1, gap:0,
              d:mk(32'h80007e01,32'h80007e01,32'h80007e01,32'h80007e01)};
    tv[8] = '{nm:"nt_clamp", a:a1, b:b1, c:mk(0,0,0,0), mode:2'b00, nt:5'd20, gap:0, d:mk(304,352,688,800)};

    bus.valid_in = 1'b0; bus.ready_out = 1'b0; bus.A = '0; bus.B = '0; bus.C = '0;
    bus.num_tiles_i = '0; bus.mode_i = '0;
    bus_s.valid_in = 1'b0; bus_s.ready_out = 1'b0; bus_s.A = '0; bus_s.B = '0; bus_s.C = '0;
    bus_s.num_tiles_i = '0; bus_s.mode_i = '0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst.D", 128'(bus.D), 128'(0));
    chk("rst.vo", 128'(bus.valid_out), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.ready_in", 128'(bus.ready_in), 128'(0));
    rst_n = 1'b1;
    step();
    chk("rel.ready_in", 128'(bus.ready_in), 128'(1));

    for (int v = 0; v < 9; v++) begin
      feed(tv[v].nm, tv[v].a, tv[v].b, tv[v].c, tv[v].mode, tv[v].nt, tv[v].gap);
      drain(tv[v].nm, tv[v].d);
    end

    // Backpressure: result held, no beats accepted while in OUT
    feed("bp", a1, b1, mk(1, 1, 1, 1), 2'b00, 5'd1, 0);
    bus.A = mt(17, 17, 17, 17);
    bus.C = mk(9, 9, 9, 9);
    bus.valid_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp.ready_in", 128'(bus.ready_in), 128'(0));
      step();
      chk("bp.vo", 128'(bus.valid_out), 128'(1));
      chk("bp.D", 128'(bus.D), 128'(d1));
    end
    bus.valid_in = 1'b0;
    drain("bp", d1);
    feed("post_bp", a1, b1, mk(0, 0, 0, 0), 2'b00, 5'd1, 0);
    drain("post_bp", mk(19, 22, 43, 50));

    // Reset in the middle of accumulation
    bus.A = a1; bus.B = b1; bus.C = mk(0, 0, 0, 0); bus.mode_i = 2'b00;
    bus.num_tiles_i = 5'd3; bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    chk("mid.busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid.rdy_low", 128'(bus.ready_in), 128'(0));
    step();
    chk("mid.D", 128'(bus.D), 128'(0));
    chk("mid.vo", 128'(bus.valid_out), 128'(0));
    chk("mid.busy0", 128'(busy), 128'(0));
    rst_n = 1'b1;
    step();
    chk("mid.rdy", 128'(bus.ready_in), 128'(1));
    feed("after_rst", a1, b1, mk(1, 1, 1, 1), 2'b00, 5'd1, 0);
    drain("after_rst", d1);

    // Saturating instance, ACC_W=8
    bus_s.A = mt(127, 127, 127, 127); bus_s.B = mt(127, 127, 127, 127);
    bus_s.C = '0; bus_s.num_tiles_i = 5'd1; bus_s.mode_i = 2'b00; bus_s.valid_in = 1'b1;
    step();
    bus_s.valid_in = 1'b0;
    chk("sat_hi.vo", 128'(bus_s.valid_out), 128'(1));
    chk("sat_hi.D", 128'(bus_s.D), 128'(32'h7f7f7f7f));
    bus_s.ready_out = 1'b1;
    step();
    bus_s.ready_out = 1'b0;
    chk("sat_hi.busy", 128'(busy_s), 128'(0));
    bus_s.B = mt(128, 128, 128, 128); bus_s.valid_in = 1'b1;
    step();
    bus_s.valid_in = 1'b0;
    chk("sat_lo.D", 128'(bus_s.D), 128'(32'h80808080));
    bus_s.ready_out = 1'b1;
    step();
    bus_s.ready_out = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
